// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM card/PIN datapath.
// Holds the PIN verifier state encoding and its default limits.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        WRONG,
        GRANTED,
        LOCKED
    } pin_state_t;

    localparam int PIN_DIGITS      = 4;
    localparam int PIN_MAX_TRIES   = 3;
    localparam int PIN_TIMEOUT_CYC = 1000;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/pin_entry_shreg.sv
// Keypad digit collector: shifts legal BCD digits in MS-first and counts them,
// saturating at DIGITS; illegal or surplus digits are dropped.
module pin_entry_shreg
    import atm_pkg::*;
#(
    parameter int P_WIDTH = 16,
    parameter int DIGITS  = PIN_DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic [3:0]         digit,
    output logic [P_WIDTH-1:0] entry,
    output logic [2:0]         count,
    output logic               accepted
);

    assign accepted = shift && is_bcd(digit) && (count < 3'(DIGITS));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            entry <= '0;
            count <= '0;
        end else if (accepted) begin
            entry <= {entry[P_WIDTH-5:0], digit};
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/pin_verifier.sv
// PIN verifier: collects a keypad PIN, compares it with the card's stored
// password, limits retries and grants access or retains the card.
module pin_verifier
    import atm_pkg::*;
#(
    parameter int P_WIDTH     = 16,
    parameter int DIGITS      = PIN_DIGITS,
    parameter int MAX_TRIES   = PIN_MAX_TRIES,
    parameter int TIMEOUT_CYC = PIN_TIMEOUT_CYC,
    parameter int T_WIDTH     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [P_WIDTH-1:0] password,
    input  logic               pass_en,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               enter,
    input  logic               cancel,
    output logic               pin_ok,
    output logic               pin_wrong,
    output logic               card_retain,
    output logic               timeout,
    output logic [2:0]         digit_count,
    output logic [1:0]         tries_left
);

    pin_state_t         state, next_state;
    logic [T_WIDTH-1:0] timer, timer_d;
    logic [1:0]         tries_d;
    logic               pin_ok_d, pin_wrong_d, card_retain_d, timeout_d;

    logic [P_WIDTH-1:0] entry;
    logic               accepted;
    logic               full, timer_hit, match, short_enter;
    logic               clear, shift;

    assign full        = (digit_count == 3'(DIGITS));
    assign timer_hit   = (timer == T_WIDTH'(TIMEOUT_CYC - 1));
    // An unknown card (password 0) can never match, even against "0000".
    assign match       = (entry == password) && (password != '0);
    assign short_enter = enter && !full;

    // The entry register must survive ENTRY->CHECK so CHECK can compare it.
    assign clear = (state == IDLE) || (state == WRONG) || (next_state == IDLE);
    assign shift = (state == ENTRY) && (next_state == ENTRY) && !enter && digit_valid;

    pin_entry_shreg #(
        .P_WIDTH(P_WIDTH),
        .DIGITS (DIGITS)
    ) u_entry (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .shift   (shift),
        .digit   (digit),
        .entry   (entry),
        .count   (digit_count),
        .accepted(accepted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pass_en) next_state = ENTRY;
            end
            ENTRY: begin
                if (!pass_en || cancel || timer_hit) next_state = IDLE;
                else if (enter && full)              next_state = CHECK;
            end
            CHECK: begin
                if (!pass_en)           next_state = IDLE;
                else if (match)         next_state = GRANTED;
                else if (tries_left <= 2'd1) next_state = LOCKED;
                else                    next_state = WRONG;
            end
            WRONG: begin
                next_state = pass_en ? ENTRY : IDLE;
            end
            GRANTED, LOCKED: begin
                if (!pass_en) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so a level drops on the
    // same edge that leaves GRANTED or LOCKED.
    always_comb begin
        pin_ok_d      = (next_state == GRANTED);
        pin_wrong_d   = (next_state == WRONG);
        card_retain_d = (next_state == LOCKED);
        timeout_d     = (state == ENTRY) && pass_en && !cancel && timer_hit;
        tries_d       = tries_left;
        timer_d       = '0;

        if (state == IDLE && next_state == ENTRY) begin
            tries_d = 2'(MAX_TRIES);
        end else if (state == CHECK && (next_state == WRONG || next_state == LOCKED)
                     && tries_left != 2'd0) begin
            tries_d = tries_left - 2'd1;
        end

        if (state == ENTRY && next_state == ENTRY && !short_enter && !accepted) begin
            timer_d = timer + T_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            tries_left  <= 2'(MAX_TRIES);
            pin_ok      <= 1'b0;
            pin_wrong   <= 1'b0;
            card_retain <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timer       <= timer_d;
            tries_left  <= tries_d;
            pin_ok      <= pin_ok_d;
            pin_wrong   <= pin_wrong_d;
            card_retain <= card_retain_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pin_verifier.sv
// Self-checking bench for pin_verifier: a small PIN/retry model pushes the
// expected verdict for each submit; it is popped when the verdict appears.
module tb_pin_verifier;
    import atm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] password;
    logic        pass_en, digit_valid, enter, cancel;
    logic [3:0]  digit;
    logic        pin_ok, pin_wrong, card_retain, timeout;
    logic [2:0]  digit_count;
    logic [1:0]  tries_left;

    pin_verifier #(
        .P_WIDTH    (16),
        .DIGITS     (4),
        .MAX_TRIES  (3),
        .TIMEOUT_CYC(16),
        .T_WIDTH    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .password   (password),
        .pass_en    (pass_en),
        .digit_valid(digit_valid),
        .digit      (digit),
        .enter      (enter),
        .cancel     (cancel),
        .pin_ok     (pin_ok),
        .pin_wrong  (pin_wrong),
        .card_retain(card_retain),
        .timeout    (timeout),
        .digit_count(digit_count),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    ok;
        int    wrong;
        int    retain;
        int    tries;
    } verdict_t;

    verdict_t    sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_pw, m_entry;
    int          m_count, m_tries;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [15:0] pw);
        m_pw     = pw;
        password = pw;
        pass_en  = 1'b1;
        tick();
        m_entry = '0;
        m_count = 0;
        m_tries = 3;
        check("start_count", digit_count, 0);
        check("start_tries", tries_left, m_tries);
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        if (d <= 4'd9 && m_count < 4) begin
            m_entry = {m_entry[11:0], d};
            m_count++;
        end
        check("digit_count", digit_count, m_count);
    endtask

    task automatic submit(input string tag);
        verdict_t v, got;
        v.tag = tag;
        if (m_entry == m_pw && m_pw != 16'h0) begin
            v.ok = 1; v.wrong = 0; v.retain = 0;
        end else begin
            m_tries = m_tries - 1;
            v.ok = 0; v.retain = (m_tries == 0); v.wrong = !v.retain;
        end
        v.tries = m_tries;
        sb.push_back(v);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check({tag, "_check_ok"}, pin_ok, 0);
        check({tag, "_check_wrong"}, pin_wrong, 0);
        tick();
        got = sb.pop_front();
        check({got.tag, "_ok"}, pin_ok, got.ok);
        check({got.tag, "_wrong"}, pin_wrong, got.wrong);
        check({got.tag, "_retain"}, card_retain, got.retain);
        check({got.tag, "_tries"}, tries_left, got.tries);
        if (got.wrong != 0) begin
            tick();
            check({got.tag, "_wrong_pulse_end"}, pin_wrong, 0);
            check({got.tag, "_count_cleared"}, digit_count, 0);
            m_entry = '0;
            m_count = 0;
        end
    endtask

    task automatic end_session(input string tag);
        pass_en = 1'b0;
        tick();
        check({tag, "_end_ok"}, pin_ok, 0);
        check({tag, "_end_retain"}, card_retain, 0);
    endtask

    initial begin
        rst = 1'b1; password = '0; pass_en = 1'b0; digit_valid = 1'b0;
        digit = '0; enter = 1'b0; cancel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ok", pin_ok, 0);
        check("rst_wrong", pin_wrong, 0);
        check("rst_retain", card_retain, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", digit_count, 0);
        check("rst_tries", tries_left, 3);

        // Correct PIN on the first try.
        start_session(16'h3370);
        key(4'd3); key(4'd3); key(4'd7); key(4'd0);
        submit("good");
        tick();
        check("good_hold", pin_ok, 1);
        check("good_hold_tries", tries_left, 3);
        end_session("good");

        // Three wrong attempts exhaust the retries.
        start_session(16'h3506);
        for (int a = 0; a < 3; a++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd4);
            submit($sformatf("bad%0d", a));
        end
        tick();
        check("locked_hold", card_retain, 1);
        check("locked_tries", tries_left, 0);
        end_session("locked");

        // Illegal digit A is dropped; a fifth digit is not needed.
        start_session(16'h4076);
        key(4'd4); key(4'd0); key(4'hA); key(4'd7); key(4'd6);
        submit("illegal_digit");
        end_session("illegal_digit");

        // Unknown card never matches.
        start_session(16'h0000);
        key(4'd0); key(4'd0); key(4'd0); key(4'd0);
        submit("unknown_card");
        end_session("unknown_card");

        // Entry timeout after 16 idle cycles.
        start_session(16'h1234);
        key(4'd2); key(4'd5);
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("no_timeout_%0d", i), timeout, 0);
        end
        tick();
        check("timeout_pulse", timeout, 1);
        check("timeout_count", digit_count, 0);
        tick();
        check("timeout_single", timeout, 0);
        end_session("timeout");

        // Cancel mid-entry.
        start_session(16'h1234);
        key(4'd1); key(4'd2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_count", digit_count, 0);
        check("cancel_ok", pin_ok, 0);
        end_session("cancel");

        // Reset while access is granted.
        start_session(16'h3370);
        key(4'd3); key(4'd3); key(4'd7); key(4'd0);
        submit("pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_granted_ok", pin_ok, 0);
        check("rst_granted_count", digit_count, 0);
        check("rst_granted_tries", tries_left, 3);
        check("rst_granted_retain", card_retain, 0);
        check("sb_empty", sb.size(), 0);
        pass_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
